// File: rtl/mem_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pipelined
// Description : MEM pipeline stage for the 16-bit processor. Synchronous
//               word-addressed data memory, BEQ/BNE branch resolution and a
//               registered MEM/WB boundary with stall/flush control.
//               Optional feature macro: ADDR_CHECK_EN (out-of-range address
//               detection with a sticky addrErr flag; otherwise addresses
//               wrap modulo DEPTH and addrErr is tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_pipelined #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int REG_W  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              BranchNe,
  input  logic              Zero,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic [REG_W-1:0]  RegDst,
  output logic              PCSrc,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_readData,
  output logic [DATA_W-1:0] wb_aluResult,
  output logic              wb_MemToReg,
  output logic [REG_W-1:0]  wb_RegDst,
  output logic              addrErr
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_readData;
  logic [DATA_W-1:0] r_wb_aluResult;
  logic              r_wb_MemToReg;
  logic [REG_W-1:0]  r_wb_RegDst;

  logic              w_go;
  logic              w_oob;
  logic              w_we;
  logic [ADDR_W-1:0] w_idx;

  assign w_go  = in_valid & ~stall & ~flush;
  assign w_idx = address[ADDR_W-1:0];

`ifdef ADDR_CHECK_EN
  // One extra bit so DEPTH is representable even when it equals 2**DATA_W.
  localparam logic [DATA_W:0] C_DEPTH = (DATA_W+1)'(DEPTH);

  logic r_addrErr;

  assign w_oob   = w_go & (MemRead | MemWrite) & ({1'b0, address} >= C_DEPTH);
  assign addrErr = r_addrErr;

  // Sticky error flag: set by any out-of-range access, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   r_addrErr <= 1'b0;
    else if (w_oob) r_addrErr <= 1'b1;
  end
`else
  // Without checking the upper address bits are simply ignored (wrap).
  assign w_oob   = 1'b0;
  assign addrErr = 1'b0;
`endif

  // A store held in reset must not land, hence the reset_n term.
  assign w_we = reset_n & w_go & MemWrite & ~w_oob;

  // Branch decision is combinational and deliberately ignores stall.
  assign PCSrc = reset_n & in_valid & ~flush & Branch & (Zero ^ BranchNe);

  // Data memory write port; the array itself has no reset.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_idx] <= writeData;
  end

  // MEM/WB register: reset > flush > stall > capture/bubble. The read of
  // r_mem sees the pre-edge contents, giving read-before-write on RMW.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_readData  <= '0;
      r_wb_aluResult <= '0;
      r_wb_MemToReg  <= 1'b0;
      r_wb_RegDst    <= '0;
    end else if (flush) begin
      r_wb_valid     <= 1'b0;
    end else if (stall) begin
      r_wb_valid     <= r_wb_valid;
    end else if (in_valid) begin
      r_wb_valid     <= 1'b1;
      r_wb_readData  <= (MemRead & ~w_oob) ? r_mem[w_idx] : '0;
      r_wb_aluResult <= address;
      r_wb_MemToReg  <= MemRead;
      r_wb_RegDst    <= RegDst;
    end else begin
      r_wb_valid     <= 1'b0;
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_readData  = r_wb_readData;
  assign wb_aluResult = r_wb_aluResult;
  assign wb_MemToReg  = r_wb_MemToReg;
  assign wb_RegDst    = r_wb_RegDst;

endmodule
`default_nettype wire
